// File: rtl/regfile_wb_arbiter.sv
// Single write-port arbiter for the 32x32 register file: pipeline writeback (A) has
// priority, the multi-cycle unit (B) is buffered and protected by a starvation counter.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int DEPTH        = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_a_we,
    input  logic [4:0]  i_a_waddr,
    input  logic [31:0] i_a_wdata,
    input  logic        i_b_valid,
    input  logic [4:0]  i_b_waddr,
    input  logic [31:0] i_b_wdata,
    output logic        o_b_ready,
    output logic        o_stall,
    output logic        o_we,
    output logic [4:0]  o_waddr,
    output logic [31:0] o_wdata
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    fifo_addr [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt, starve_nxt;

    logic a_req, b_pend, force_b, push;
    logic grant_a, grant_b;

    assign a_req   = i_a_we && (i_a_waddr != 5'd0);
    assign b_pend  = (count != '0);
    assign force_b = b_pend && (starve_cnt == SW'(STARVE_LIMIT));

    // Both handshake outputs come from registered state only, so the pipeline can
    // act on them without a combinational path back through its own request.
    assign o_stall   = force_b && !i_rst;
    assign o_b_ready = (count != CW'(DEPTH)) && !i_rst;

    // Writes to r0 complete the handshake but never take a slot.
    assign push = i_b_valid && o_b_ready && (i_b_waddr != 5'd0);

    always_comb begin
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        starve_nxt = '0;
        if (force_b) begin
            grant_b = 1'b1;
        end else if (a_req) begin
            grant_a    = 1'b1;
            starve_nxt = b_pend ? starve_cnt + 1'b1 : '0;
        end else if (b_pend) begin
            grant_b = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            o_we       <= 1'b0;
            o_waddr    <= 5'd0;
            o_wdata    <= 32'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (grant_b)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !grant_b)
                count <= count + 1'b1;
            else if (!push && grant_b)
                count <= count - 1'b1;
            starve_cnt <= starve_nxt;
            o_we       <= grant_a || grant_b;
            if (grant_b) begin
                o_waddr <= fifo_addr[rd_ptr];
                o_wdata <= fifo_data[rd_ptr];
            end else if (grant_a) begin
                o_waddr <= i_a_waddr;
                o_wdata <= i_a_wdata;
            end
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= i_b_waddr;
            fifo_data[wr_ptr] <= i_b_wdata;
        end
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter for the pipelined core's 32x32 register file, which has a single write port. It shares that port between two writers. The pipeline writeback stage (requester A) has priority. The multi-cycle execution unit (requester B, e.g. mul/div) is buffered in a small FIFO and is guaranteed forward progress by a starvation counter that stalls the pipeline. The block's registered outputs drive the register file's write port directly.

## Interface
- STARVE_LIMIT, 4: consecutive cycles B may wait with pending data while A is granted, before B is forced.
- DEPTH, 2: B FIFO depth in entries; power of two, at least 2.
- i_clk  in  1  clock; all state updates on posedge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_a_we  in  1  pipeline writeback request.
- i_a_waddr  in  5  A destination register.
- i_a_wdata  in  32  A write data.
- i_b_valid  in  1  B offers a result.
- i_b_waddr  in  5  B destination register.
- i_b_wdata  in  32  B write data.
- o_b_ready  out  1  B FIFO can accept; a push occurs when i_b_valid && o_b_ready.
- o_stall  out  1  pipeline must freeze and hold A's request stable this cycle.
- o_we  out  1  register-file write enable (registered).
- o_waddr  out  5  register-file write address (registered).
- o_wdata  out  32  register-file write data (registered).

## Operation
- State: B FIFO (DEPTH entries of {addr, data}, with read pointer, write pointer and count); starve_cnt (width $clog2(STARVE_LIMIT+1)); output registers.
- Definitions:
  - a_req = i_a_we && i_a_waddr != 0.
  - b_pend = FIFO count != 0.
  - force = b_pend && starve_cnt == STARVE_LIMIT.
- o_stall = force && !i_rst. It is derived from registered state only, never from same-cycle inputs.
- o_b_ready = (count != DEPTH) && !i_rst. A push when full is impossible because ready is low.
- Grant, evaluated each cycle:
  - force: grant B (pop head). A is ignored this cycle; the pipeline re-presents it next cycle.
  - else if a_req: grant A. starve_cnt increments if b_pend, otherwise clears.
  - else if b_pend: grant B (pop).
  - else: no grant.
- starve_cnt clears on every B grant and whenever the FIFO is empty.
- Granted request: output registers load {1, addr, data} at the next edge. With no grant, o_we loads 0 and o_waddr/o_wdata hold their previous values.
- Address 0:
  - A with waddr 0 is treated as no request.
  - B with waddr 0 is still accepted (handshake completes) but is discarded at push and never occupies a FIFO slot.
- Simultaneous push and pop in one cycle is legal; count is unchanged. The pushed entry is never granted in its own push cycle.
- Ordering: B writes leave in arrival order. Cross-requester RAW/WAW ordering to the same register is the issue logic's responsibility, not this block's.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (async, immediate): o_we=0, o_waddr=0, o_wdata=0, count=0, pointers=0, starve_cnt=0, o_stall=0, o_b_ready=0 while i_rst is high. After release: o_b_ready=1.
- Reset mid-operation: all FIFO contents are lost, and any o_we pulse in flight is cancelled immediately.
- Latency, A: request in cycle n gives o_we=1 in cycle n+1; the register-file contents update at the end of n+1.
- Latency, B: push in cycle n gives the earliest o_we in cycle n+2, when A is idle in n+1.
- Worst-case B wait with A saturating: STARVE_LIMIT cycles, then one forced cycle.
- o_stall is high for exactly one cycle per forced grant. It can recur every STARVE_LIMIT+1 cycles while B stays pending.

## Test plan
- Reset: assert i_rst mid-cycle -> outputs are 0 immediately. After release, o_b_ready=1 and o_stall=0.
- A only: i_a_we=1, waddr=5, wdata=0xDEADBEEF in cycle n -> o_we=1, o_waddr=5, o_wdata=0xDEADBEEF in n+1. A register-file read of r5 returns 0xDEADBEEF in n+2.
- B only: push (7, 0x12345678) in cycle n with A idle -> o_we=1, o_waddr=7 in n+2. o_b_ready stays 1 throughout.
- Starvation: A writes r1..r9 back-to-back and B pushes (9, 0xCAFEF00D) in cycle 0:
  - A is granted in cycles 1-4.
  - Cycle 5: o_stall=1 and B is granted; o_we shows r9=0xCAFEF00D in cycle 6.
  - A's held request is granted in cycle 6 and appears in cycle 7.
  - No A write is lost or duplicated.
- Full/order: with A saturating, push (10, 0xA) and (11, 0xB) -> o_b_ready=0. The third B valid is held until a pop frees a slot. Outputs appear as 10 then 11, then the third.
- Zero address: A with waddr=0 -> o_we stays 0. B push with waddr=0 -> handshake completes, count is unchanged, no o_we.
- Reset with 2 FIFO entries pending -> no further o_we after reset.
